// File: rtl/tournament_chooser.sv
// Tournament chooser: a table of saturating selector counters that picks
// between the local and global predictor for each D-stage PC. Counters are
// trained in M. A clear sequence runs after every reset. If an M-stage write
// lands on the entry being read in D in the same cycle, the written value is
// forwarded to the D-stage read.
// Optional build macro: CHOOSER_GHIST_EN hashes the read index with a global
// history register. In that build the update index comes from idxM.
//
// state | meaning
// ------+-----------------------------------------------------------------
// INIT  | table clear in progress: one entry per cycle set to weakly-local
// RUN   | normal operation: predictions from the table, M-stage training
module tournament_chooser #(
    parameter int IDX_W  = 5,
    parameter int CTR_W  = 2,
    parameter int PC_LSB = 2,
    parameter int HIST_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcD,
    input  logic             localpred,
    input  logic             globalpred,
    input  logic             branchM,
    input  logic             actual_takeM,
    input  logic             localPred_M,
    input  logic             globalPred_M,
    input  logic [31:0]      pcM,
    input  logic [IDX_W-1:0] idxM,
    output logic [IDX_W-1:0] predIdxD,
    output logic             use_global,
    output logic             pred,
    output logic             init_busy
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_WL  = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] clrPtr;
    logic [CTR_W-1:0] ctrTable [ENTRIES];

    logic             running;
    logic [IDX_W-1:0] pcIdxD;
    logic [IDX_W-1:0] rdIdx;
    logic [IDX_W-1:0] upIdx;
    logic             localWrong;
    logic             globalWrong;
    logic             incSel;
    logic             decSel;
    logic             updEn;
    logic [CTR_W-1:0] updCur;
    logic [CTR_W-1:0] updNext;
    logic [CTR_W-1:0] rdCur;
    logic [CTR_W-1:0] rdEff;
    logic             unusedSink;

    // Reset is folded in here so the outputs are forced during the rst cycle too.
    assign running = !rst && (state == RUN);
    assign pcIdxD  = pcD[PC_LSB+IDX_W-1:PC_LSB];

`ifdef CHOOSER_GHIST_EN
    logic [HIST_W-1:0] ghr;

    // History holds at zero until the table is ready, then shifts in each resolved branch.
    always_ff @(posedge clk) begin
        if (rst || state == INIT) begin
            ghr <= '0;
        end else if (branchM) begin
            ghr <= {ghr[HIST_W-2:0], actual_takeM};
        end
    end

    assign rdIdx      = pcIdxD ^ ghr[IDX_W-1:0];
    assign upIdx      = idxM;
    assign unusedSink = ^{pcD, pcM, ghr[HIST_W-1]};
`else
    assign rdIdx      = pcIdxD;
    assign upIdx      = pcM[PC_LSB+IDX_W-1:PC_LSB];
    assign unusedSink = (^{pcD, pcM, idxM}) ^ (HIST_W > 0);
`endif

    // Sequence the clear pointer through every entry, then stay in RUN until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            clrPtr <= '0;
        end else begin
            case (state)
                INIT: begin
                    clrPtr <= clrPtr + IDX_W'(1);
                    if (clrPtr == {IDX_W{1'b1}}) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign localWrong  = localPred_M ^ actual_takeM;
    assign globalWrong = globalPred_M ^ actual_takeM;
    assign incSel      = localWrong & ~globalWrong;
    assign decSel      = ~localWrong & globalWrong;
    assign updEn       = running & branchM & (incSel | decSel);
    assign updCur      = ctrTable[upIdx];

    // Saturating step toward whichever predictor was right.
    always_comb begin
        updNext = updCur;
        if (incSel && updCur != CTR_MAX) begin
            updNext = updCur + CTR_ONE;
        end else if (decSel && updCur != '0) begin
            updNext = updCur - CTR_ONE;
        end
    end

    // Table write port. Clear writes take priority, and nothing is written while rst is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                ctrTable[clrPtr] <= CTR_WL;
            end else if (updEn) begin
                ctrTable[upIdx] <= updNext;
            end
        end
    end

    assign rdCur = ctrTable[rdIdx];
    assign rdEff = (updEn && upIdx == rdIdx) ? updNext : rdCur;

    assign predIdxD   = rdIdx;
    assign use_global = running & rdEff[CTR_W-1];
    assign pred       = use_global ? globalpred : localpred;
    assign init_busy  = !running;

endmodule

// File: tb/tb_tournament_chooser.sv
// Bench for tournament_chooser at IDX_W=5, CTR_W=2, PC_LSB=2. The reference
// model keeps each counter as a plain integer with clamped arithmetic and
// tracks the clear as a remaining-cycle count.
module tb_tournament_chooser;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcD, pcM;
    logic        localpred, globalpred, branchM, actual_takeM;
    logic        localPred_M, globalPred_M;
    logic [4:0]  idxM;
    logic [4:0]  predIdxD;
    logic        use_global, pred, init_busy;

    int checks   = 0;
    int failures = 0;
    int mdl [32];
    int initRem  = 32;
    int ghr      = 0;

    tournament_chooser #(.IDX_W(5), .CTR_W(2), .PC_LSB(2), .HIST_W(8)) dut (
        .clk(clk), .rst(rst), .pcD(pcD), .localpred(localpred), .globalpred(globalpred),
        .branchM(branchM), .actual_takeM(actual_takeM), .localPred_M(localPred_M),
        .globalPred_M(globalPred_M), .pcM(pcM), .idxM(idxM),
        .predIdxD(predIdxD), .use_global(use_global), .pred(pred), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    function automatic int rIdx();
        int r;
        r = (pcD >> 2) & 31;
`ifdef CHOOSER_GHIST_EN
        r = r ^ (ghr & 31);
`endif
        return r;
    endfunction

    function automatic int uIdx();
`ifdef CHOOSER_GHIST_EN
        return int'(idxM);
`else
        return (pcM >> 2) & 31;
`endif
    endfunction

    function automatic int stepCtr(int v);
        bit fl, fg;
        fl = localPred_M ^ actual_takeM;
        fg = globalPred_M ^ actual_takeM;
        if (fl && !fg) return (v < 3) ? v + 1 : 3;
        if (!fl && fg) return (v > 0) ? v - 1 : 0;
        return v;
    endfunction

    function automatic bit mBusy();
        return rst || initRem > 0;
    endfunction

    function automatic bit expUseGlobal();
        int v;
        if (mBusy()) return 1'b0;
        v = mdl[rIdx()];
        if (branchM && uIdx() == rIdx()) v = stepCtr(v);
        return v >= 2;
    endfunction

    // Advance the model for the coming edge, then move to just after it.
    task automatic tick();
        if (rst) begin
            initRem = 32;
            ghr     = 0;
            foreach (mdl[i]) mdl[i] = 1;
        end else if (initRem > 0) begin
            initRem--;
        end else if (branchM) begin
            int u;
            u = uIdx();
            mdl[u] = stepCtr(mdl[u]);
            ghr = ((ghr << 1) | int'(actual_takeM)) & 255;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setUpd(input bit br, input bit lM, input bit gM, input bit act);
        branchM = br; localPred_M = lM; globalPred_M = gM; actual_takeM = act;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            localpred  = 1'($urandom);
            globalpred = 1'($urandom);
            pcD = 32'($urandom_range(0, 31)) << 2;
            pcM = 32'($urandom_range(0, 31)) << 2;
            setUpd(1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            if (init_busy !== 1'b1) begin
                $display("FAIL reset_busy cyc=%0d got=%b exp=1", i, init_busy); failures++;
            end
            checks++;
            if (use_global !== 1'b0 || pred !== localpred) begin
                $display("FAIL reset_outputs cyc=%0d use_global=%b pred=%b exp 0/%b", i, use_global, pred, localpred);
                failures++;
            end
            checks++;
            tick();
        end
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        if (init_busy !== 1'b0) begin
            $display("FAIL reset_done got=%b exp=0", init_busy); failures++;
        end
        checks++;
        for (int i = 0; i < 32; i++) begin
            pcD = 32'(i) << 2; globalpred = 1'b1; localpred = 1'b0;
            #1;
            if (use_global !== 1'b0 || pred !== 1'b0) begin
                $display("FAIL reset_entry idx=%0d use_global=%b pred=%b exp 0/0", i, use_global, pred);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid_init();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pcM = 32'h0C;
        for (int i = 0; i < 32; i++) begin
            setUpd(1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            if (init_busy !== 1'b1) begin
                $display("FAIL midinit_busy cyc=%0d got=%b exp=1", i, init_busy); failures++;
            end
            checks++;
            tick();
        end
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        pcD = 32'h0C; globalpred = 1'b1; localpred = 1'b0;
        #1;
        if (init_busy !== 1'b0 || use_global !== 1'b0) begin
            $display("FAIL midinit_entry busy=%b use_global=%b exp 0/0", init_busy, use_global);
            failures++;
        end
        checks++;
    endtask

    task automatic test_saturation();
        bit expInc [3] = '{1'b1, 1'b1, 1'b1};
        bit expDec [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        pcM = 32'h40; globalpred = 1'b1; localpred = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pcD = 32'h00;
            setUpd(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            setUpd(1'b0, 1'b0, 1'b0, 1'b0);
            pcD = 32'h40;
            #1;
            if (use_global !== expInc[i] || pred !== expInc[i]) begin
                $display("FAIL sat_inc step=%0d use_global=%b pred=%b exp %b", i, use_global, pred, expInc[i]);
                failures++;
            end
            checks++;
        end
        for (int i = 0; i < 4; i++) begin
            pcD = 32'h00;
            setUpd(1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            setUpd(1'b0, 1'b0, 1'b0, 1'b0);
            pcD = 32'h40;
            #1;
            if (use_global !== expDec[i]) begin
                $display("FAIL sat_dec step=%0d got=%b exp=%b", i, use_global, expDec[i]);
                failures++;
            end
            checks++;
        end
        localpred = 1'b1; globalpred = 1'b0;
        #1;
        if (pred !== 1'b1) begin
            $display("FAIL sat_follow_local got=%b exp=1", pred); failures++;
        end
        checks++;
    endtask

    task automatic test_both_same();
        pcM = 32'h44; pcD = 32'h00;
        setUpd(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        setUpd(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        pcD = 32'h44; globalpred = 1'b1; localpred = 1'b0;
        #1;
        if (use_global !== 1'b0) begin
            $display("FAIL same_hold got=%b exp=0", use_global); failures++;
        end
        checks++;
        pcD = 32'h00;
        setUpd(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        pcD = 32'h44;
        #1;
        if (use_global !== 1'b1) begin
            $display("FAIL same_then_inc got=%b exp=1", use_global); failures++;
        end
        checks++;
    endtask

    task automatic test_bypass();
        globalpred = 1'b1; localpred = 1'b0;
        pcD = 32'h14; pcM = 32'h18;
        setUpd(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        if (use_global !== 1'b0) begin
            $display("FAIL bypass_other_idx got=%b exp=0", use_global); failures++;
        end
        checks++;
        tick();
        pcM = 32'h14;
        #1;
        if (use_global !== 1'b1 || pred !== 1'b1) begin
            $display("FAIL bypass_same_cycle use_global=%b pred=%b exp 1/1", use_global, pred);
            failures++;
        end
        checks++;
        tick();
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        if (use_global !== 1'b1) begin
            $display("FAIL bypass_stored got=%b exp=1", use_global); failures++;
        end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit expG;
            rst        = ($urandom_range(0, 99) == 0);
            pcD        = (32'($urandom_range(0, 7)) << 2) | (32'($urandom) & 32'hFFFF_FF83);
            pcM        = (32'($urandom_range(0, 7)) << 2) | (32'($urandom) & 32'hFFFF_FF83);
            idxM       = 5'($urandom_range(0, 7));
            localpred  = 1'($urandom);
            globalpred = 1'($urandom);
            setUpd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            expG = expUseGlobal();
            if (init_busy !== mBusy()) begin
                $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, init_busy, mBusy()); failures++;
            end
            checks++;
            if (use_global !== expG || pred !== (expG ? globalpred : localpred)) begin
                $display("FAIL rand_pred cyc=%0d use_global=%b pred=%b exp %b/%b", i, use_global, pred,
                         expG, (expG ? globalpred : localpred));
                failures++;
            end
            checks++;
            if (int'(predIdxD) != rIdx()) begin
                $display("FAIL rand_idx cyc=%0d got=%0d exp=%0d", i, predIdxD, rIdx()); failures++;
            end
            checks++;
            tick();
        end
        rst = 1'b0;
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef CHOOSER_GHIST_EN
    task automatic test_ghist();
        bit acts [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        rst = 1'b1;
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        for (int i = 0; i < 4; i++) begin
            setUpd(1'b1, acts[i], acts[i], acts[i]);
            tick();
        end
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        pcD = 32'h00; globalpred = 1'b1; localpred = 1'b0;
        #1;
        if (predIdxD !== 5'h0B) begin
            $display("FAIL ghist_idx got=%h exp=0b", predIdxD); failures++;
        end
        checks++;
        idxM = 5'h0B;
        setUpd(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        if (use_global !== 1'b1) begin
            $display("FAIL ghist_bypass got=%b exp=1", use_global); failures++;
        end
        checks++;
        tick();
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        pcD = 32'h74;
        #1;
        if (predIdxD !== 5'h0B || use_global !== 1'b1) begin
            $display("FAIL ghist_entry idx=%h use_global=%b exp 0b/1", predIdxD, use_global); failures++;
        end
        checks++;
    endtask
`endif

    initial begin
        rst = 1'b1; pcD = '0; pcM = '0; idxM = '0;
        localpred = 1'b0; globalpred = 1'b0;
        setUpd(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        test_reset();
        test_reset_mid_init();
`ifndef CHOOSER_GHIST_EN
        test_saturation();
        test_both_same();
        test_bypass();
`endif
        test_random();
`ifdef CHOOSER_GHIST_EN
        test_ghist();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tournament_chooser.md
Name: tournament_chooser

Overview:
- Parametrised local/global chooser for the tournament branch predictor.
- Holds 2^IDX_W saturating CTR_W-bit selector counters, indexed by PC (optionally hashed with global history).
- Read in D stage; emits the final direction prediction by muxing localpred/globalpred. Trained in M stage.
- Adds a multi-cycle table-clear FSM after reset and same-cycle update-to-read bypass.

Parameters:
IDX_W, 5, table index width; the table holds 2^IDX_W entries
CTR_W, 2, selector counter width (>=2); MSB=1 selects global
PC_LSB, 2, lowest PC bit used for the index
HIST_W, 8, global history register width (>=IDX_W); only used with CHOOSER_GHIST_EN

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
pcD  in  32  D-stage PC (read)
localpred  in  1  local predictor direction for pcD
globalpred  in  1  global predictor direction for pcD
branchM  in  1  M-stage instruction is a conditional branch
actual_takeM  in  1  resolved direction
localPred_M  in  1  local prediction carried to M
globalPred_M  in  1  global prediction carried to M
pcM  in  32  M-stage PC (update)
idxM  in  IDX_W  index carried from predIdxD to M; used only with CHOOSER_GHIST_EN
predIdxD  out  IDX_W  index used for this D-stage read
use_global  out  1  chooser decision (counter MSB)
pred  out  1  final prediction = use_global ? globalpred : localpred
init_busy  out  1  table clear in progress

Behaviour:
- FSM states: INIT and RUN. rst=1 forces INIT with clr_ptr=0, including when rst is asserted mid-INIT or mid-RUN.
- INIT: each cycle writes WL = 2^(CTR_W-1)-1 (weakly local) to entry clr_ptr, then clr_ptr+1.
  - After writing entry 2^IDX_W-1, the next state is RUN.
  - The clear takes exactly 2^IDX_W cycles after rst deasserts.
- In INIT and while rst=1: init_busy=1, use_global=0, pred=localpred, and all updates are dropped.
- In RUN: init_busy=0.
- Read index rI = pcD[PC_LSB+IDX_W-1:PC_LSB]. Update index uI = pcM[same bits]. predIdxD = rI.
- Update happens when RUN and branchM:
  - fl = localPred_M^actual_takeM, fg = globalPred_M^actual_takeM.
  - fl=1, fg=0: counter+1, saturating at 2^CTR_W-1.
  - fl=0, fg=1: counter-1, saturating at 0.
  - Otherwise: hold; no write.
- Bypass: if an update writes in this cycle and uI==rI, use_global/pred use the post-update value combinationally. Otherwise they use the stored value.
- Read and output path is combinational; latency 0. Table write takes effect at the next posedge.
- Counter arithmetic is unsigned CTR_W bits; no wrap at either end.

Optional Feature:
- Macro CHOOSER_GHIST_EN.
- Defined:
  - HIST_W-bit GHR, reset to 0, also held at 0 during INIT.
  - In RUN, on branchM, GHR <= {GHR[HIST_W-2:0], actual_takeM}.
  - rI = pc bits XOR GHR[IDX_W-1:0]; predIdxD = rI.
  - The update uses uI = idxM; pcM is ignored.
  - The bypass compares idxM with rI.
- Undefined: no GHR, idxM is ignored, and indexing is PC-only as above.

Test Plan (IDX_W=5, CTR_W=2, PC_LSB=2, macro off unless stated):
1. Reset then clear: rst high 1 cycle, then low → init_busy=1 for exactly 32 cycles, then 0. Every entry reads 01, so use_global=0 and pred=localpred.
2. Reset mid-init: assert rst at clear cycle 10, release → init_busy stays 1 for a further full 32 cycles. A branchM update issued during INIT leaves entry 01.
3. Saturation: pcM=0x40 (idx 16), fl=1/fg=0 three times → entry 01→10→11→11. With pcD=0x40, globalpred=1, localpred=0 → pred=1. Four fl=0/fg=1 updates → 11→10→01→00→00, and pred follows localpred.
4. Both wrong or both right: pcM=0x44 with localPred_M=globalPred_M=actual_takeM=1, then all three set so both mispredict → entry stays 01.
5. Bypass: entry 5 holds 01; in the same cycle pcD=pcM=0x14, branchM=1, fl=1/fg=0 → use_global=1 in that cycle, and entry reads 10 on the next cycle.
6. CHOOSER_GHIST_EN: after RUN, four branchM updates with actual_takeM=1,0,1,1 → GHR=0x0B. Then pcD=0x00 → predIdxD=5'h0B, and an update with idxM=0x0B, fl=1/fg=0 moves entry 11 from 01 to 10.
